// File: rtl/board_input_conditioner_if.sv
// Board pin bundle: raw KEY/SW pins in, conditioned levels and event pulses out.
// The board side is master; the conditioner is slave.
interface board_input_conditioner_if #(
    parameter int N_KEYS = 4,
    parameter int N_SW   = 10
);
    logic [N_KEYS-1:0] key_n;
    logic [N_SW-1:0]   sw;
    logic [N_KEYS-1:0] key_level;
    logic [N_KEYS-1:0] key_press;
    logic [N_KEYS-1:0] key_repeat;
    logic [N_KEYS-1:0] key_release;
    logic [N_SW-1:0]   sw_level;
    logic [N_SW-1:0]   sw_change;

    modport master (
        output key_n, sw,
        input  key_level, key_press, key_repeat, key_release, sw_level, sw_change
    );

    modport slave (
        input  key_n, sw,
        output key_level, key_press, key_repeat, key_release, sw_level, sw_change
    );
endinterface

// File: rtl/board_input_conditioner.sv
// Synchronise, debounce and edge-detect board keys and switches, with optional key auto-repeat.
// Repeat FSM per key:  IDLE | key released or not yet repeating;  DELAY | waiting for first repeat;  REPEAT | periodic repeats
module board_input_conditioner #(
    parameter int N_KEYS          = 4,
    parameter int N_SW            = 10,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int KEY_ACTIVE_LOW  = 1,
    parameter int REPEAT_EN       = 0,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input  logic CLOCK_50,
    input  logic reset,
    board_input_conditioner_if.slave bus
);
    localparam int NCH   = N_KEYS + N_SW;
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    // Keys and switches share one channel vector, keys in the low bits, all in "1 = active" sense.
    logic [NCH-1:0]                  w_raw;
    logic [SYNC_STAGES-1:0][NCH-1:0] r_sync;
    logic [NCH-1:0]                  w_s;
    logic [NCH-1:0]                  r_level;
    logic [CNT_W-1:0]                r_cnt [NCH];
    logic [NCH-1:0]                  w_accept;
    logic [NCH-1:0]                  w_rise;
    logic [NCH-1:0]                  w_fall;

    logic [N_KEYS-1:0] r_key_press;
    logic [N_KEYS-1:0] r_key_repeat;
    logic [N_KEYS-1:0] r_key_release;
    logic [N_SW-1:0]   r_sw_change;

    assign w_raw = {bus.sw, (KEY_ACTIVE_LOW != 0) ? ~bus.key_n : bus.key_n};
    assign w_s   = r_sync[SYNC_STAGES-1];

    always_comb begin
        w_accept = '0;
        for (int i = 0; i < NCH; i++) begin
            w_accept[i] = (w_s[i] != r_level[i]) && (r_cnt[i] == CNT_W'(DEBOUNCE_CYCLES));
        end
    end

    assign w_rise = w_accept & w_s;
    assign w_fall = w_accept & ~w_s;

    // The counter holds DEBOUNCE_CYCLES on the accepting edge, so it never exceeds the compare value.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_sync  <= '0;
            r_level <= '0;
            for (int i = 0; i < NCH; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], w_raw};
            for (int i = 0; i < NCH; i++) begin
                if (w_s[i] == r_level[i]) begin
                    r_cnt[i] <= '0;
                end else if (w_accept[i]) begin
                    r_level[i] <= w_s[i];
                    r_cnt[i]   <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_key_release <= '0;
            r_sw_change   <= '0;
        end else begin
            r_key_release <= w_fall[N_KEYS-1:0];
            r_sw_change   <= w_accept[NCH-1:N_KEYS];
        end
    end

    generate
        if (REPEAT_EN != 0) begin : g_rep
            localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
            localparam int REP_W   = $clog2(REP_MAX + 1);

            typedef enum logic [1:0] {ST_IDLE, ST_DELAY, ST_REPEAT} rep_state_t;

            rep_state_t       r_state [N_KEYS];
            logic [REP_W-1:0] r_rcnt  [N_KEYS];

            // Down-counter is loaded with N-1 so the terminal count lands exactly N cycles later.
            always_ff @(posedge CLOCK_50) begin
                if (reset) begin
                    r_key_press  <= '0;
                    r_key_repeat <= '0;
                    for (int k = 0; k < N_KEYS; k++) begin
                        r_state[k] <= ST_IDLE;
                        r_rcnt[k]  <= '0;
                    end
                end else begin
                    for (int k = 0; k < N_KEYS; k++) begin
                        r_key_press[k]  <= w_rise[k];
                        r_key_repeat[k] <= 1'b0;
                        case (r_state[k])
                            ST_IDLE: begin
                                if (w_rise[k]) begin
                                    r_state[k] <= ST_DELAY;
                                    r_rcnt[k]  <= REP_W'(REPEAT_DELAY - 1);
                                end
                            end
                            ST_DELAY, ST_REPEAT: begin
                                if (w_fall[k]) begin
                                    r_state[k] <= ST_IDLE;
                                    r_rcnt[k]  <= '0;
                                end else if (r_rcnt[k] == '0) begin
                                    r_key_press[k]  <= 1'b1;
                                    r_key_repeat[k] <= 1'b1;
                                    r_state[k]      <= ST_REPEAT;
                                    r_rcnt[k]       <= REP_W'(REPEAT_PERIOD - 1);
                                end else begin
                                    r_rcnt[k] <= r_rcnt[k] - REP_W'(1);
                                end
                            end
                            default: begin
                                r_state[k] <= ST_IDLE;
                                r_rcnt[k]  <= '0;
                            end
                        endcase
                    end
                end
            end
        end else begin : g_norep
            always_ff @(posedge CLOCK_50) begin
                if (reset) begin
                    r_key_press  <= '0;
                    r_key_repeat <= '0;
                end else begin
                    r_key_press  <= w_rise[N_KEYS-1:0];
                    r_key_repeat <= '0;
                end
            end
        end
    endgenerate

    assign bus.key_level   = r_level[N_KEYS-1:0];
    assign bus.sw_level    = r_level[NCH-1:N_KEYS];
    assign bus.key_press   = r_key_press;
    assign bus.key_repeat  = r_key_repeat;
    assign bus.key_release = r_key_release;
    assign bus.sw_change   = r_sw_change;
endmodule

// File: tb/tb_board_input_conditioner.sv
// Scoreboard bench: a window-based reference model predicts every pulse; a negedge monitor checks the DUT.
module tb_board_input_conditioner;
    localparam int NK   = 4;
    localparam int NS   = 10;
    localparam int NCH  = NK + NS;
    localparam int S    = 2;
    localparam int D    = 4;
    localparam int RD   = 10;
    localparam int RP   = 5;
    localparam int MAXC = 8000;

    logic CLOCK_50 = 1'b0;
    logic reset    = 1'b1;
    always #5 CLOCK_50 = ~CLOCK_50;

    board_input_conditioner_if #(.N_KEYS(NK), .N_SW(NS)) bif ();

    board_input_conditioner #(
        .N_KEYS(NK), .N_SW(NS), .SYNC_STAGES(S), .DEBOUNCE_CYCLES(D),
        .KEY_ACTIVE_LOW(1), .REPEAT_EN(1), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
    ) dut (
        .CLOCK_50(CLOCK_50),
        .reset(reset),
        .bus(bif)
    );

    typedef struct {
        int          cyc;
        bit [NK-1:0] press;
        bit [NK-1:0] rep;
        bit [NK-1:0] rel;
        bit [NS-1:0] chg;
    } ev_t;

    int           checks = 0;
    int           errors = 0;
    int           cyc = 0;
    bit           done = 1'b0;
    bit [NCH-1:0] hist [MAXC];
    bit [NCH-1:0] m_level = '0;
    bit           m_held [NK];
    int           m_tp [NK];
    ev_t          exp_q [$];

    // Reference rule: a channel flips at edge n when the pin values it sampled at edges
    // n-S-D .. n-S all equal the opposite of the current level. Repeats fire at press+RD+k*RP.
    always @(posedge CLOCK_50) begin
        bit [NCH-1:0] smp;
        bit [NCH-1:0] rise;
        bit [NCH-1:0] fall;
        bit [NK-1:0]  rep;
        bit           ok;
        ev_t          e;
        cyc++;
        smp = reset ? '0 : {bif.sw, ~bif.key_n};
        if (cyc < MAXC) hist[cyc] = smp;
        if (reset) begin
            for (int j = 1; j < S; j++) if (cyc - j >= 0) hist[cyc-j] = '0;
            m_level = '0;
            for (int k = 0; k < NK; k++) m_held[k] = 1'b0;
        end else begin
            rise = '0;
            fall = '0;
            rep  = '0;
            for (int ch = 0; ch < NCH; ch++) begin
                if (cyc - S - D >= 0) begin
                    ok = 1'b1;
                    for (int k = 0; k <= D; k++) if (hist[cyc-S-k][ch] == m_level[ch]) ok = 1'b0;
                    if (ok) begin
                        if (m_level[ch]) fall[ch] = 1'b1;
                        else             rise[ch] = 1'b1;
                    end
                end
            end
            for (int k = 0; k < NK; k++) begin
                if (m_held[k] && !fall[k] && cyc >= m_tp[k] + RD && ((cyc - m_tp[k] - RD) % RP) == 0)
                    rep[k] = 1'b1;
                if (rise[k]) begin
                    m_held[k] = 1'b1;
                    m_tp[k]   = cyc;
                end
                if (fall[k]) m_held[k] = 1'b0;
            end
            m_level = m_level ^ (rise | fall);
            if (|{rise, fall, rep}) begin
                e.cyc   = cyc;
                e.press = rise[NK-1:0] | rep;
                e.rep   = rep;
                e.rel   = fall[NK-1:0];
                e.chg   = rise[NCH-1:NK] | fall[NCH-1:NK];
                exp_q.push_back(e);
            end
        end
    end

    always @(negedge CLOCK_50) begin
        ev_t e;
        if (!done && cyc > 0) begin
            checks++;
            if ({bif.sw_level, bif.key_level} !== m_level) begin
                errors++;
                $display("FAIL level cyc=%0d got=%h exp=%h", cyc, {bif.sw_level, bif.key_level}, m_level);
            end
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                checks++;
                errors++;
                $display("FAIL missing_pulse cyc=%0d got=none exp_at=%0d", cyc, exp_q[0].cyc);
                void'(exp_q.pop_front());
            end
            if (|{bif.key_press, bif.key_repeat, bif.key_release, bif.sw_change}) begin
                checks++;
                if (exp_q.size() == 0 || exp_q[0].cyc != cyc) begin
                    errors++;
                    $display("FAIL unexpected_pulse cyc=%0d got press=%h rep=%h rel=%h chg=%h exp=none",
                             cyc, bif.key_press, bif.key_repeat, bif.key_release, bif.sw_change);
                end else begin
                    e = exp_q.pop_front();
                    if (bif.key_press !== e.press || bif.key_repeat !== e.rep ||
                        bif.key_release !== e.rel || bif.sw_change !== e.chg) begin
                        errors++;
                        $display("FAIL pulse_value cyc=%0d got press=%h rep=%h rel=%h chg=%h exp press=%h rep=%h rel=%h chg=%h",
                                 cyc, bif.key_press, bif.key_repeat, bif.key_release, bif.sw_change,
                                 e.press, e.rep, e.rel, e.chg);
                    end
                end
            end
        end
    end

    task automatic check_zero(input string nm);
        checks++;
        if ({bif.key_level, bif.key_press, bif.key_repeat, bif.key_release, bif.sw_level, bif.sw_change} !== '0) begin
            errors++;
            $display("FAIL %s got kl=%h kp=%h kr=%h krel=%h sl=%h sc=%h exp=all_zero", nm,
                     bif.key_level, bif.key_press, bif.key_repeat, bif.key_release, bif.sw_level, bif.sw_change);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge CLOCK_50);
    endtask

    initial begin
        bif.key_n = '1;
        bif.sw    = '0;
        reset     = 1'b1;
        wait_cycles(3);
        check_zero("reset_state");
        reset = 1'b0;
        wait_cycles(1);
        check_zero("post_reset");
        wait_cycles(5);

        bif.key_n[1] = 1'b0;
        wait_cycles(12);

        bif.key_n[0] = 1'b0;
        wait_cycles(3);
        bif.key_n[0] = 1'b1;
        wait_cycles(10);

        for (int i = 0; i < 4; i++) begin
            bif.key_n[2] = i[0];
            wait_cycles(1);
        end
        bif.key_n[2] = 1'b0;
        wait_cycles(12);

        bif.key_n[3] = 1'b0;
        wait_cycles(40);
        bif.key_n[3] = 1'b1;
        wait_cycles(15);
        bif.key_n[1] = 1'b1;
        bif.key_n[2] = 1'b1;
        wait_cycles(10);

        bif.sw = 10'h3FF;
        wait_cycles(10);
        bif.sw = 10'h000;
        wait_cycles(10);

        bif.key_n[1] = 1'b0;
        wait_cycles(4);
        reset = 1'b1;
        wait_cycles(1);
        check_zero("reset_mid_debounce");
        reset = 1'b0;
        wait_cycles(1);
        check_zero("after_mid_reset");
        wait_cycles(12);
        bif.key_n[1] = 1'b1;
        wait_cycles(10);

        for (int c = 0; c < 3000; c++) begin
            for (int k = 0; k < NK; k++)
                if ($urandom_range(0, 15) == 0) bif.key_n[k] = ~bif.key_n[k];
            for (int k = 0; k < NS; k++)
                if ($urandom_range(0, 15) == 0) bif.sw[k] = ~bif.sw[k];
            reset = ($urandom_range(0, 499) == 0);
            wait_cycles(1);
        end
        reset     = 1'b0;
        bif.key_n = '1;
        bif.sw    = '0;
        wait_cycles(30);

        done = 1'b1;
        while (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL missing_pulse_at_end got=none exp_at=%0d", exp_q[0].cyc);
            void'(exp_q.pop_front());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
